// File: rtl/axi_protocol_monitor.sv
// Passive AXI4 protocol monitor: sticky violation flags, first-error code,
// completed-burst counters. Burst lengths are tracked per direction in a
// small length FIFO so several bursts may be outstanding at once.

// Per-direction length tracker: FIFO of accepted burst lengths plus the
// beat counter of the burst at the head, with the last-beat checks.
module axi_protocol_monitor_track #(
    parameter int OUTST = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       addr_hs,
    input  logic [7:0] addr_len,
    input  logic       beat,
    input  logic       last,
    output logic       last_early,
    output logic       last_missing,
    output logic       no_addr,
    output logic       ovf
);
    localparam int PW = (OUTST > 1) ? $clog2(OUTST) : 1;
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(OUTST);

    logic [7:0]    mem [OUTST];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic [7:0]    beat_cnt;
    logic [7:0]    len;
    logic          empty;
    logic          full;
    logic          checked;
    logic          push;
    logic          pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    // A beat with neither a stored nor a same-cycle length cannot be checked.
    assign no_addr = beat && empty && !addr_hs;
    assign checked = beat && !no_addr;
    // With an empty FIFO the beat is judged against the incoming length.
    assign len     = empty ? addr_len : mem[rd_ptr];

    assign last_early   = checked && last && (beat_cnt != len);
    assign last_missing = checked && !last && (beat_cnt == len);
    assign pop          = checked && last && !empty;
    assign ovf          = addr_hs && full && !pop;
    // A bypassed single-beat burst is consumed in the same cycle it arrives.
    assign push         = addr_hs && !ovf && !(checked && last && empty);

    // Length storage.
    // NOTE: storage words carry no reset; the pointers and fill level alone
    // decide which entries are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= addr_len;
    end

    // FIFO pointers and fill level.
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Beat counter of the current burst; held when the beat is unchecked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        beat_cnt <= '0;
        else if (checked) beat_cnt <= last ? 8'd0 : beat_cnt + 1'b1;
    end
endmodule

module axi_protocol_monitor #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int OUTST   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    input  logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    input  logic                arready,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    input  logic                rready,
    output logic [11:0]         err,
    output logic                err_valid,
    output logic [3:0]          first_err,
    output logic [15:0]         wr_bursts,
    output logic [15:0]         rd_bursts
);
    localparam logic [2:0] SIZE_OK = 3'($clog2(DATA_W / 8));
    localparam int         TW      = $clog2(TIMEOUT + 2);
    localparam logic [TW-1:0] TO_SAT = TW'(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT);
    localparam int AF_W = ADDR_W + 13;
    localparam int WF_W = DATA_W + DATA_W / 8 + 1;

    typedef enum logic [3:0] {
        E_AW_STABLE     = 4'd0,
        E_W_STABLE      = 4'd1,
        E_AR_STABLE     = 4'd2,
        E_WLAST_EARLY   = 4'd3,
        E_WLAST_MISSING = 4'd4,
        E_RLAST_EARLY   = 4'd5,
        E_RLAST_MISSING = 4'd6,
        E_SIZE          = 4'd7,
        E_RESP          = 4'd8,
        E_TIMEOUT       = 4'd9,
        E_NO_ADDR       = 4'd10,
        E_OVF           = 4'd11
    } err_e;

    logic            aw_hs, w_beat, ar_hs, r_beat;
    logic [AF_W-1:0] aw_f, aw_f_q, ar_f, ar_f_q;
    logic [WF_W-1:0] w_f, w_f_q;
    logic            aw_stall_q, w_stall_q, ar_stall_q;
    logic [2:0]      stall;
    logic [2:0]      to_hit;
    logic [TW-1:0]   to_cnt [3];
    logic            w_early, w_missing, w_noaddr, aw_ovf;
    logic            r_early, r_missing, r_noaddr, ar_ovf;
    logic [11:0]     viol;
    logic [3:0]      first_idx;

    assign aw_hs  = awvalid && awready;
    assign w_beat = wvalid && wready;
    assign ar_hs  = arvalid && arready;
    assign r_beat = rvalid && rready;
    assign aw_f   = {awaddr, awlen, awsize, awburst};
    assign ar_f   = {araddr, arlen, arsize, arburst};
    assign w_f    = {wdata, wstrb, wlast};
    // Stall order matches to_cnt: 0 = AW, 1 = W, 2 = AR.
    assign stall  = {arvalid && !arready, wvalid && !wready, awvalid && !awready};

    axi_protocol_monitor_track #(.OUTST(OUTST)) u_wr_track (
        .clk(clk), .reset(reset), .addr_hs(aw_hs), .addr_len(awlen),
        .beat(w_beat), .last(wlast), .last_early(w_early),
        .last_missing(w_missing), .no_addr(w_noaddr), .ovf(aw_ovf)
    );

    axi_protocol_monitor_track #(.OUTST(OUTST)) u_rd_track (
        .clk(clk), .reset(reset), .addr_hs(ar_hs), .addr_len(arlen),
        .beat(r_beat), .last(rlast), .last_early(r_early),
        .last_missing(r_missing), .no_addr(r_noaddr), .ovf(ar_ovf)
    );

    // Previous-cycle stall flags and payloads for the stability rules.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_stall_q <= 1'b0;
            w_stall_q  <= 1'b0;
            ar_stall_q <= 1'b0;
            aw_f_q     <= '0;
            ar_f_q     <= '0;
            w_f_q      <= '0;
        end else begin
            aw_stall_q <= stall[0];
            w_stall_q  <= stall[1];
            ar_stall_q <= stall[2];
            aw_f_q     <= aw_f;
            ar_f_q     <= ar_f;
            w_f_q      <= w_f;
        end
    end

    // Consecutive wait cycles per valid, saturating one past the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) to_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!stall[i])               to_cnt[i] <= '0;
                else if (to_cnt[i] != TO_SAT) to_cnt[i] <= to_cnt[i] + 1'b1;
            end
        end
    end

    // This cycle's violations and the lowest index among them.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        viol      = '0;
        first_idx = '0;
        for (int i = 0; i < 3; i++) to_hit[i] = stall[i] && (to_cnt[i] >= TO_LIM);
        viol[E_AW_STABLE]     = aw_stall_q && (!awvalid || (aw_f != aw_f_q));
        viol[E_W_STABLE]      = w_stall_q  && (!wvalid  || (w_f  != w_f_q));
        viol[E_AR_STABLE]     = ar_stall_q && (!arvalid || (ar_f != ar_f_q));
        viol[E_WLAST_EARLY]   = w_early;
        viol[E_WLAST_MISSING] = w_missing;
        viol[E_RLAST_EARLY]   = r_early;
        viol[E_RLAST_MISSING] = r_missing;
        viol[E_SIZE]          = (awvalid && (awsize != SIZE_OK)) ||
                                (arvalid && (arsize != SIZE_OK));
        viol[E_RESP]          = (bvalid && bready && (bresp != 2'd0)) ||
                                (r_beat && (rresp != 2'd0));
        viol[E_TIMEOUT]       = |to_hit;
        viol[E_NO_ADDR]       = w_noaddr || r_noaddr;
        viol[E_OVF]           = aw_ovf || ar_ovf;
        for (int i = 11; i >= 0; i--) begin
            if (viol[i]) first_idx = 4'(i);
        end
    end

    // Sticky flags, first-error code and burst counters; clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            err       <= '0;
            first_err <= '0;
            wr_bursts <= '0;
            rd_bursts <= '0;
        end else begin
            err <= err | viol;
            if ((err == '0) && (viol != '0)) first_err <= first_idx;
            if (w_beat && wlast) wr_bursts <= wr_bursts + 1'b1;
            if (r_beat && rlast) rd_bursts <= rd_bursts + 1'b1;
        end
    end

    assign err_valid = |err;
endmodule

// File: doc/axi_protocol_monitor.md
# axi_protocol_monitor

Synthesisable, parametrised AXI4 protocol monitor that sits passively on one master–slave AXI link. It is the hardware successor to the formal-only AXI checker. It tracks burst lengths through per-direction length FIFOs, supports multiple outstanding bursts and configurable data width, and adds handshake timeouts. Violations are reported at run time as sticky error flags, a first-error code and burst counters, readable by the control block or a bench.

## Interface
- `DATA_W`, default 32: AXI data width (32/64/128); the legal `axsize` is log2(`DATA_W`/8).
- `ADDR_W`, default 32: address width.
- `OUTST`, default 4: length-FIFO depth per direction, which is the maximum number of outstanding bursts (power of 2).
- `TIMEOUT`, default 16: maximum consecutive cycles a valid may wait for its ready.
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `clear`, in, 1: synchronous clear of errors, first-error code and counters.
- AW channel inputs: `awaddr[ADDR_W]`, `awlen[8]`, `awsize[3]`, `awburst[2]`, `awvalid`, `awready`.
- W channel inputs: `wdata[DATA_W]`, `wstrb[DATA_W/8]`, `wlast`, `wvalid`, `wready`.
- B channel inputs: `bresp[2]`, `bvalid`, `bready`.
- AR channel inputs: `araddr[ADDR_W]`, `arlen[8]`, `arsize[3]`, `arburst[2]`, `arvalid`, `arready`.
- R channel inputs: `rresp[2]`, `rlast`, `rvalid`, `rready`.
- `err`, out, 12: sticky violation flags; bit map is given under Operation.
- `err_valid`, out, 1: high when any bit of `err` is set.
- `first_err`, out, 4: index of the first violation recorded.
- `wr_bursts`, out, 16: count of completed write bursts (W beat with `wlast` accepted).
- `rd_bursts`, out, 16: count of completed read bursts (R beat with `rlast` accepted).

## Operation
- Handshake definition: a handshake occurs on a cycle where `xvalid && xready` is high.
- Error bits:
  - 0 `AW_STABLE`: after a cycle with `awvalid && !awready`, either `awvalid` falls or any of `awaddr`/`awlen`/`awsize`/`awburst` changes.
  - 1 `W_STABLE`: the same rule on `wvalid`, applied to `wdata`/`wstrb`/`wlast`.
  - 2 `AR_STABLE`: the same rule on `arvalid`, applied to the AR fields.
  - 3 `WLAST_EARLY`: a W beat has `wlast=1` while `wbeat != len`.
  - 4 `WLAST_MISSING`: a W beat has `wlast=0` while `wbeat == len`.
  - 5 `RLAST_EARLY`: the R-channel equivalent of bit 3.
  - 6 `RLAST_MISSING`: the R-channel equivalent of bit 4.
  - 7 `SIZE`: `awvalid` or `arvalid` is high with `axsize` != log2(`DATA_W`/8).
  - 8 `RESP`: an accepted B beat or R beat carries a response != 0.
  - 9 `TIMEOUT`: `awvalid`, `wvalid` or `arvalid` waits more than `TIMEOUT` cycles without ready.
  - 10 `NO_ADDR`: a W or R beat arrives while the matching length FIFO is empty and there is no same-cycle address handshake.
  - 11 `OVF`: an AW or AR handshake occurs while its FIFO is full and no pop happens in the same cycle. The length is dropped.
- Length FIFOs:
  - An AW/AR handshake pushes `axlen`.
  - The head entry is `len`.
  - A beat with `xlast=1` pops the head and resets the 8-bit beat counter to 0.
  - Any other beat increments the beat counter.
- Bypass: if the FIFO is empty and an address handshake coincides with a data beat, that beat is checked against the incoming `axlen`.
- Bit 10 handling: when bit 10 fires, the beat is not checked for bits 3–6 and the beat counter is held.
- Timeout counters: one per valid (AW, W, AR). Each increments while `valid && !ready`, clears otherwise, and saturates at `TIMEOUT+1`.
- `first_err`: loaded with the lowest set index from the cycle in which `err` first becomes nonzero; held until `clear`.
- Counters: `wr_bursts` and `rd_bursts` wrap at 16 bits.
- Clear precedence: `clear` has precedence over any same-cycle violation; that violation is lost.

## Timing
- Reset values: `err`=0, `err_valid`=0, `first_err`=0, both burst counters=0, FIFOs empty, beat counters 0, timeout counters 0, stability history cleared.
- Error latency:
  - Violations are registered, so `err` rises on the clock edge after the offending cycle.
  - Stability errors compare cycle N against the registered values from cycle N-1, so they flag at the edge after N.
  - `TIMEOUT` sets on the edge ending wait cycle `TIMEOUT+1`.
- `err_valid` is combinational from `err`.
- FIFO simultaneity: push and pop in the same cycle are legal at any fill level. When the FIFO is full, a same-cycle pop frees the slot, so no `OVF` is raised.
- Burst counters update on the edge after the last beat.
- Reset mid-burst: all tracking state is discarded; the beats that follow, with no preceding address handshake, raise `NO_ADDR`.

## Test plan
- AW handshake `awlen=3`, then 4 W beats with `wlast` only on the 4th → `err`=0, `wr_bursts`=1.
- AR handshake `arlen=0`, then R beat with `rlast=0` → bit 6 set, `first_err`=6. A later `arsize`=3 at `DATA_W`=32 → bit 7 also set, `first_err` stays 6.
- Hold `awvalid` without `awready`, change `awaddr` 0x10→0x14 → bit 0 set one cycle later. Separately, hold `arvalid` for 17 cycles with no `arready` at `TIMEOUT`=16 → bit 9 set.
- Five AW handshakes with no W beats at `OUTST`=4 → bit 11 set on the 5th. With a `wlast` beat in the same cycle as the 5th → no error.
- Single-beat W in the same cycle as the AW handshake (`awlen=0`, `wlast=1`) → no error. B beat with `bresp=2` → bit 8 set. `clear` pulse → all outputs return to 0.
